// File: rtl/exmem_reg_if.sv
// EX/MEM pipeline register bus: EX-side inputs, hazard controls and MEM-side outputs.
interface exmem_reg_if;
    localparam int unsigned CTRL_W  = 8;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned NADDR_W = 12;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned FLAG_W  = 3;

    logic                stall;
    logic                flush;
    logic                valid_in;
    logic                ALU_done;
    logic [CTRL_W-1:0]   ctrl_in;
    logic [REG_W-1:0]    DestReg_in;
    logic [ADDR_W-1:0]   ALU_addr_in;
    logic [NADDR_W-1:0]  NON_ALU_addr_in;
    logic [DATA_W-1:0]   MemWrite_data_in;
    logic [FLAG_W-1:0]   flags_in;
    logic                flag_we_in;

    logic [CTRL_W-1:0]   ctrl_out;
    logic [REG_W-1:0]    DestReg_out;
    logic [ADDR_W-1:0]   ALU_addr_out;
    logic [NADDR_W-1:0]  NON_ALU_addr_out;
    logic [DATA_W-1:0]   MemWrite_data_out;
    logic                valid_out;
    logic                ex_stall_req;
    logic [FLAG_W-1:0]   flags_out;
    logic                alu_timeout;

    modport slave (
        input  stall, flush, valid_in, ALU_done, ctrl_in, DestReg_in, ALU_addr_in,
               NON_ALU_addr_in, MemWrite_data_in, flags_in, flag_we_in,
        output ctrl_out, DestReg_out, ALU_addr_out, NON_ALU_addr_out, MemWrite_data_out,
               valid_out, ex_stall_req, flags_out, alu_timeout
    );

    modport master (
        output stall, flush, valid_in, ALU_done, ctrl_in, DestReg_in, ALU_addr_in,
               NON_ALU_addr_in, MemWrite_data_in, flags_in, flag_we_in,
        input  ctrl_out, DestReg_out, ALU_addr_out, NON_ALU_addr_out, MemWrite_data_out,
               valid_out, ex_stall_req, flags_out, alu_timeout
    );
endinterface

// File: rtl/exmem_reg.sv
// EX/MEM pipeline register with ALU-wait tracking and a sticky ALU timeout flag.
// Define EXMEM_FLAGS_EN to add the {N,Z,V} flag register; otherwise flags_out is tied to zero.
module exmem_reg #(
    parameter int unsigned ALU_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    exmem_reg_if.slave  bus
);
    localparam int unsigned CTRL_W  = 8;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned NADDR_W = 12;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned FLAG_W  = 3;
    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(ALU_TIMEOUT);

    typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    wcnt_q, wcnt_d;
    logic                valid_q, valid_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [REG_W-1:0]    dest_q, dest_d;
    logic [ADDR_W-1:0]   alu_addr_q, alu_addr_d;
    logic [NADDR_W-1:0]  non_alu_q, non_alu_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                timeout_q, timeout_d;
    logic                capture_c;

    assign capture_c = ~bus.flush & ~bus.stall & bus.valid_in & bus.ALU_done;

    // Priority below reset: flush, then stall (hold), then capture / wait bubble / idle bubble.
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        valid_d    = valid_q;
        ctrl_d     = ctrl_q;
        dest_d     = dest_q;
        alu_addr_d = alu_addr_q;
        non_alu_d  = non_alu_q;
        wdata_d    = wdata_q;
        timeout_d  = timeout_q;
        if (bus.flush) begin
            state_d    = ST_RUN;
            wcnt_d     = '0;
            valid_d    = 1'b0;
            ctrl_d     = '0;
            dest_d     = '0;
            alu_addr_d = '0;
            non_alu_d  = '0;
            wdata_d    = '0;
        end else if (!bus.stall) begin
            if (bus.valid_in && bus.ALU_done) begin
                state_d    = ST_RUN;
                wcnt_d     = '0;
                valid_d    = 1'b1;
                ctrl_d     = bus.ctrl_in;
                dest_d     = bus.DestReg_in;
                alu_addr_d = bus.ALU_addr_in;
                non_alu_d  = bus.NON_ALU_addr_in;
                wdata_d    = bus.MemWrite_data_in;
            end else if (bus.valid_in) begin
                // Waiting on the ALU: emit a bubble, data outputs keep their last value.
                state_d = ST_WAIT;
                valid_d = 1'b0;
                ctrl_d  = '0;
                if (state_q == ST_WAIT)
                    wcnt_d = (wcnt_q == '1) ? wcnt_q : wcnt_q + CNT_W'(1);
                else
                    wcnt_d = CNT_W'(1);
                if (wcnt_d >= TIMEOUT_CNT)
                    timeout_d = 1'b1;
            end else begin
                state_d = ST_RUN;
                wcnt_d  = '0;
                valid_d = 1'b0;
                ctrl_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wcnt_q     <= '0;
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            dest_q     <= '0;
            alu_addr_q <= '0;
            non_alu_q  <= '0;
            wdata_q    <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            dest_q     <= dest_d;
            alu_addr_q <= alu_addr_d;
            non_alu_q  <= non_alu_d;
            wdata_q    <= wdata_d;
            timeout_q  <= timeout_d;
        end
    end

`ifdef EXMEM_FLAGS_EN
    logic [FLAG_W-1:0] flags_q, flags_d;

    // Flags only move on a real capture of a flag-writing instruction.
    always_comb begin
        flags_d = flags_q;
        if (capture_c && bus.flag_we_in)
            flags_d = bus.flags_in;
    end

    always_ff @(posedge clk) begin
        if (rst) flags_q <= '0;
        else     flags_q <= flags_d;
    end

    assign bus.flags_out = flags_q;
`else
    logic unused_flags;
    assign unused_flags  = ^{bus.flags_in, bus.flag_we_in, capture_c};
    assign bus.flags_out = FLAG_W'(0);
`endif

    assign bus.valid_out         = valid_q;
    assign bus.ctrl_out          = ctrl_q;
    assign bus.DestReg_out       = dest_q;
    assign bus.ALU_addr_out      = alu_addr_q;
    assign bus.NON_ALU_addr_out  = non_alu_q;
    assign bus.MemWrite_data_out = wdata_q;
    assign bus.alu_timeout       = timeout_q;
    assign bus.ex_stall_req      = bus.valid_in & ~bus.ALU_done & ~bus.flush;
endmodule

// File: tb/tb_exmem_reg.sv
// Directed bench for exmem_reg: vector table plus timeout / flush-in-WAIT / stall-in-WAIT sequences.
module tb_exmem_reg;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    exmem_reg_if bus ();

    exmem_reg #(.ALU_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, flush, vin, done;
        logic [7:0]  ctrl;
        logic [4:0]  dest;
        logic [31:0] addr;
        logic [11:0] non;
        logic [31:0] wd;
        logic [2:0]  flags;
        logic        fwe;
        logic        x_sreq;
        logic        x_valid;
        logic [7:0]  x_ctrl;
        logic [4:0]  x_dest;
        logic [31:0] x_addr;
        logic [11:0] x_non;
        logic [31:0] x_wd;
        logic [2:0]  x_flags;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic st, input logic fl, input logic vi, input logic dn,
                         input logic [7:0] c, input logic [4:0] d, input logic [31:0] a,
                         input logic [11:0] n, input logic [31:0] w, input logic [2:0] f, input logic fw);
        rst                  = r;
        bus.stall            = st;
        bus.flush            = fl;
        bus.valid_in         = vi;
        bus.ALU_done         = dn;
        bus.ctrl_in          = c;
        bus.DestReg_in       = d;
        bus.ALU_addr_in      = a;
        bus.NON_ALU_addr_in  = n;
        bus.MemWrite_data_in = w;
        bus.flags_in         = f;
        bus.flag_we_in       = fw;
    endtask

    function automatic logic [2:0] flag_exp(input logic [2:0] f);
`ifdef EXMEM_FLAGS_EN
        return f;
`else
        return 3'(f & 3'b000);
`endif
    endfunction

    task automatic chk_outs(input string tag, input logic v, input logic [7:0] c, input logic [4:0] d,
                            input logic [31:0] a, input logic [11:0] n, input logic [31:0] w,
                            input logic [2:0] f, input logic to);
        chk({tag, ".valid_out"},   32'(bus.valid_out),         32'(v));
        chk({tag, ".ctrl_out"},    32'(bus.ctrl_out),          32'(c));
        chk({tag, ".DestReg_out"}, 32'(bus.DestReg_out),       32'(d));
        chk({tag, ".ALU_addr"},    bus.ALU_addr_out,           a);
        chk({tag, ".NON_ALU"},     32'(bus.NON_ALU_addr_out),  32'(n));
        chk({tag, ".wdata"},       bus.MemWrite_data_out,      w);
        chk({tag, ".flags_out"},   32'(bus.flags_out),         32'(flag_exp(f)));
        chk({tag, ".alu_timeout"}, 32'(bus.alu_timeout),       32'(to));
    endtask

    // One ALU-wait edge with a fixed dummy instruction; checks only the timeout flag and bubble.
    task automatic wait_edge(input string tag, input logic st, input logic exp_to);
        drive(1'b0, st, 1'b0, 1'b1, 1'b0, 8'h03, 5'd2, 32'h10, 12'h20, 32'h30, 3'b000, 1'b0);
        #1;
        chk({tag, ".ex_stall_req"}, 32'(bus.ex_stall_req), 32'd1);
        step();
        chk({tag, ".alu_timeout"}, 32'(bus.alu_timeout), 32'(exp_to));
        if (!st) chk({tag, ".ctrl_out"}, 32'(bus.ctrl_out), 32'd0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 32'h0, 12'h0, 32'h0, 3'b000, 1'b0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = '{1,1,1,1,1, 8'hFF,5'h1F,32'hFFFFFFFF,12'hFFF,32'hFFFFFFFF,3'b111,1, 0,
                     0,8'h00,5'd0,32'h0,12'h0,32'h0,3'b000};
        vecs[1]  = '{0,0,0,1,1, 8'h05,5'd7,32'h1234,12'h0AB,32'hDEADBEEF,3'b101,1, 0,
                     1,8'h05,5'd7,32'h1234,12'h0AB,32'hDEADBEEF,3'b101};
        vecs[2]  = '{0,0,0,1,0, 8'h13,5'd9,32'h5555,12'h123,32'h0BADF00D,3'b010,0, 1,
                     0,8'h00,5'd7,32'h1234,12'h0AB,32'hDEADBEEF,3'b101};
        vecs[3]  = vecs[2];
        vecs[4]  = vecs[2];
        vecs[5]  = '{0,0,0,1,1, 8'h13,5'd9,32'h5555,12'h123,32'h0BADF00D,3'b010,0, 0,
                     1,8'h13,5'd9,32'h5555,12'h123,32'h0BADF00D,3'b101};
        vecs[6]  = '{0,1,0,1,1, 8'hFF,5'd3,32'hAAAA,12'hFFF,32'hCAFE,3'b111,1, 0,
                     1,8'h13,5'd9,32'h5555,12'h123,32'h0BADF00D,3'b101};
        vecs[7]  = '{0,1,0,1,0, 8'hFF,5'd3,32'hAAAA,12'hFFF,32'hCAFE,3'b111,1, 1,
                     1,8'h13,5'd9,32'h5555,12'h123,32'h0BADF00D,3'b101};
        vecs[8]  = '{0,1,1,1,1, 8'hFF,5'd3,32'hAAAA,12'hFFF,32'hCAFE,3'b111,1, 0,
                     0,8'h00,5'd0,32'h0,12'h0,32'h0,3'b101};
        vecs[9]  = '{0,0,0,0,1, 8'h44,5'd2,32'h7777,12'h555,32'h1111,3'b111,1, 0,
                     0,8'h00,5'd0,32'h0,12'h0,32'h0,3'b101};
        vecs[10] = '{0,0,0,1,1, 8'h02,5'h1F,32'hFFFFFFFF,12'hFFF,32'h1,3'b011,1, 0,
                     1,8'h02,5'h1F,32'hFFFFFFFF,12'hFFF,32'h1,3'b011};
        vecs[11] = '{0,0,1,1,0, 8'h01,5'd4,32'h8888,12'h222,32'h2222,3'b100,1, 0,
                     0,8'h00,5'd0,32'h0,12'h0,32'h0,3'b011};
        vecs[12] = '{0,0,0,0,0, 8'h00,5'd0,32'h0,12'h0,32'h0,3'b000,0, 0,
                     0,8'h00,5'd0,32'h0,12'h0,32'h0,3'b011};

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 32'h0, 12'h0, 32'h0, 3'b000, 1'b0);
        step();

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].vin, vecs[i].done,
                  vecs[i].ctrl, vecs[i].dest, vecs[i].addr, vecs[i].non, vecs[i].wd,
                  vecs[i].flags, vecs[i].fwe);
            #1;
            chk($sformatf("vec%0d.ex_stall_req", i), 32'(bus.ex_stall_req), 32'(vecs[i].x_sreq));
            step();
            chk_outs($sformatf("vec%0d", i), vecs[i].x_valid, vecs[i].x_ctrl, vecs[i].x_dest,
                     vecs[i].x_addr, vecs[i].x_non, vecs[i].x_wd, vecs[i].x_flags, 1'b0);
        end

        // Timeout: four ALU-wait edges raise the sticky flag, which survives capture until reset.
        for (int k = 1; k <= 6; k++)
            wait_edge($sformatf("to_wait%0d", k), 1'b0, (k >= 4) ? 1'b1 : 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h09, 5'd5, 32'hABCD, 12'h321, 32'h77, 3'b000, 1'b0);
        step();
        chk("to_capture.valid_out", 32'(bus.valid_out), 32'd1);
        chk("to_capture.alu_timeout", 32'(bus.alu_timeout), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 32'h0, 12'h0, 32'h0, 3'b000, 1'b0);
        step();
        chk("to_idle.alu_timeout", 32'(bus.alu_timeout), 32'd1);
        do_reset();
        chk_outs("to_reset", 1'b0, 8'h00, 5'd0, 32'h0, 12'h0, 32'h0, 3'b000, 1'b0);

        // Flush mid-WAIT abandons the wait and clears the counter.
        wait_edge("fl_wait1", 1'b0, 1'b0);
        wait_edge("fl_wait2", 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h03, 5'd2, 32'h10, 12'h20, 32'h30, 3'b000, 1'b0);
        #1;
        chk("fl_flush.ex_stall_req", 32'(bus.ex_stall_req), 32'd0);
        step();
        chk_outs("fl_flush", 1'b0, 8'h00, 5'd0, 32'h0, 12'h0, 32'h0, 3'b000, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h21, 5'd11, 32'h4444, 12'h0F0, 32'h5150, 3'b000, 1'b0);
        step();
        chk_outs("fl_next", 1'b1, 8'h21, 5'd11, 32'h4444, 12'h0F0, 32'h5150, 3'b000, 1'b0);
        for (int k = 1; k <= 4; k++)
            wait_edge($sformatf("fl_rewait%0d", k), 1'b0, (k == 4) ? 1'b1 : 1'b0);
        do_reset();

        // Stall mid-WAIT freezes the wait counter.
        for (int k = 1; k <= 3; k++)
            wait_edge($sformatf("st_wait%0d", k), 1'b0, 1'b0);
        wait_edge("st_hold1", 1'b1, 1'b0);
        wait_edge("st_hold2", 1'b1, 1'b0);
        wait_edge("st_wait4", 1'b0, 1'b1);
        do_reset();
        chk("st_reset.alu_timeout", 32'(bus.alu_timeout), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/exmem_reg.md
EXMEM_REG -- requirements
Module: exmem_reg

Interface
REQ-001 Parameter ALU_TIMEOUT, default 16, WAIT-state cycles before alu_timeout is raised; legal range 2..255.
REQ-002 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-003 Port rst  in  1  reset, synchronous, active-high.
REQ-004 Port stall  in  1  hazard-unit hold of this register.
REQ-005 Port flush  in  1  squash the register contents (branch/ret redirect).
REQ-006 Port valid_in  in  1  EX stage presents a real instruction.
REQ-007 Port ALU_done  in  1  EX ALU result is valid this cycle.
REQ-008 Port ctrl_in  in  8  bit map: [0]RegWrite [1]MemWrite [2]MemRead [3]MemToReg [4]MemSrc [5]branch [6]call [7]ret.
REQ-009 Port DestReg_in  in  5  destination register.
REQ-010 Port ALU_addr_in  in  32  ALU result / computed address.
REQ-011 Port NON_ALU_addr_in  in  12  direct memory address.
REQ-012 Port MemWrite_data_in  in  32  store data.
REQ-013 Port flags_in  in  3  {N,Z,V} from ALU.
REQ-014 Port flag_we_in  in  1  instruction updates flags.
REQ-015 Ports ctrl_out(8), DestReg_out(5), ALU_addr_out(32), NON_ALU_addr_out(12), MemWrite_data_out(32)  out  registered copies of the matching inputs.
REQ-016 Port valid_out  out  1  MEM stage holds a real instruction.
REQ-017 Port ex_stall_req  out  1  combinational request for upstream to hold EX.
REQ-018 Port flags_out  out  3  registered {N,Z,V}.
REQ-019 Port alu_timeout  out  1  sticky error: ALU wait exceeded ALU_TIMEOUT.

Function
REQ-020 States: RUN, WAIT; 8-bit saturating wait counter wcnt.
REQ-021 Edge priority: rst > flush > stall > capture/bubble.
REQ-022 flush: valid_out=0, ctrl_out=0, data outputs=0, state->RUN, wcnt=0; flags_out and alu_timeout unchanged.
REQ-023 stall (no flush): every output register, state and wcnt hold.
REQ-024 Capture: valid_in=1 and ALU_done=1 -> all data/ctrl latched, valid_out=1, state->RUN, wcnt=0; latency exactly one cycle.
REQ-025 valid_in=1 and ALU_done=0 -> bubble (valid_out=0, ctrl_out=0, data held), state->WAIT, wcnt increments saturating at 255.
REQ-026 valid_in=0 -> bubble, state->RUN, wcnt=0.
REQ-027 ex_stall_req = valid_in & ~ALU_done & ~flush, independent of stall.
REQ-028 When wcnt reaches ALU_TIMEOUT in WAIT, alu_timeout sets and stays set until rst; pipeline behaviour is unchanged.
REQ-029 A bubble never presents a nonzero ctrl_out bit; RegWrite/MemWrite are never asserted with valid_out=0.
REQ-030 flush during WAIT abandons the wait; next cycle is RUN with the new EX instruction.

Reset
REQ-031 rst at any cycle, including mid-WAIT: all outputs 0, state RUN, wcnt 0, alu_timeout 0, flags_out 3'b000.
REQ-032 rst overrides flush and stall in the same cycle.

Configuration
REQ-033 Macro EXMEM_FLAGS_EN defined: flags_out loads flags_in on a capture with flag_we_in=1, otherwise holds (stall/flush/bubble hold).
REQ-034 Macro EXMEM_FLAGS_EN undefined: no flag register; flags_out constant 3'b000, flags_in and flag_we_in ignored.

Verification
REQ-035 rst high 1 cycle with all inputs 1 -> every output 0 next cycle.
REQ-036 valid_in=1, ALU_done=1, ctrl_in=8'h05, DestReg_in=5'd7, ALU_addr_in=32'h1234 -> next cycle valid_out=1, ctrl_out=8'h05, DestReg_out=7, ALU_addr_out=32'h1234.
REQ-037 valid_in=1, ALU_done=0 for 3 cycles then 1 -> ex_stall_req=1 for 3 cycles, 3 bubbles, capture on 4th edge.
REQ-038 Captured valid instruction then stall=1 and flush=1 together -> valid_out=0, ctrl_out=0 next cycle.
REQ-039 ALU_TIMEOUT=4, ALU_done=0 for 6 cycles -> alu_timeout rises after 4th WAIT cycle, stays 1 after ALU_done=1 until rst.
REQ-040 EXMEM_FLAGS_EN defined, capture flags_in=3'b101 flag_we_in=1, then flag_we_in=0 flags_in=3'b010 -> flags_out 3'b101 both cycles; undefined -> 3'b000.
